// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the debug/display unit button front-end.
// The default timings assume a 100 MHz clock: 5 ms debounce, 0.5 s repeat delay, 0.25 s repeat period.
package btn_conditioner_pkg;

  localparam int unsigned DEF_N_BTN         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC  = 500_000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 25_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_chan.sv
// One button channel: 2-flop synchroniser, debouncer, edge pulses and auto-repeat strobe FSM.
// All outputs are registered and change on the same edge as btn_level.
module btn_chan
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic rep_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_act
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RC_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  logic            meta_q, meta_d;
  logic            sync_q, sync_d;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            act_q, act_d;
  state_e          state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      act_q     <= 1'b0;
      state_q   <= S_IDLE;
      rc_q      <= '0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      act_q     <= act_d;
      state_q   <= state_d;
      rc_q      <= rc_d;
    end
  end

  // Debounce: a new level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    meta_d   = btn_raw;
    sync_d   = meta_q;
    level_d  = level_q;
    db_cnt_d = '0;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync_q;
        rise    = sync_q;
        fall    = ~sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    press_d   = rise;
    release_d = fall;
  end

  // Release or losing rep_en wins over a repeat strobe due in the same cycle.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    act_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          act_d = 1'b1;
          rc_d  = '0;
          if (rep_en) state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (fall || !rep_en) begin
          state_d = S_IDLE;
        end else if (rc_q == RD_LAST) begin
          act_d   = 1'b1;
          rc_d    = '0;
          state_d = S_REPEAT;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      S_REPEAT: begin
        if (fall || !rep_en) begin
          state_d = S_IDLE;
        end else if (rc_q == RP_LAST) begin
          act_d = 1'b1;
          rc_d  = '0;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_act     = act_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front-end for the debug/display unit: N_BTN independent conditioned channels
// producing clean level, press/release pulses and an auto-repeating act strobe.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN         = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] rep_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_act
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[gi]),
      .rep_en     (rep_en[gi]),
      .btn_level  (btn_level[gi]),
      .btn_press  (btn_press[gi]),
      .btn_release(btn_release[gi]),
      .btn_act    (btn_act[gi])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a cycle-level reference model predicts every output vector,
// a negedge monitor compares; directed scenarios add latency and strobe-count checks.
module tb_btn_conditioner;

  localparam int N   = 2;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] rep_en = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_act;

  btn_conditioner #(
    .N_BTN        (N),
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .rep_en     (rep_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_act    (btn_act)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [4*N-1:0] exp_q[$];
  int act_cnt[N];
  int press_cnt[N];
  int rel_cnt[N];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
    end
  endtask

  // Reference model: sync delay of two samples, level accepted after DEB consecutive
  // disagreeing samples, act at press and at press+RD+k*RP while held with rep_en.
  initial begin : model
    logic m_s0[N], m_s1[N], m_lvl[N];
    int   run[N], tp[N];
    bit   alive[N];
    int   n;
    logic s_old, rise, fall, act;
    int   d;
    logic [N-1:0] e_lvl, e_pr, e_rl, e_act;
    n = 0;
    for (int i = 0; i < N; i++) begin
      m_s0[i] = 0; m_s1[i] = 0; m_lvl[i] = 0; run[i] = 0; tp[i] = 0; alive[i] = 0;
    end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          m_s0[i] = 0; m_s1[i] = 0; m_lvl[i] = 0; run[i] = 0; alive[i] = 0;
        end
        exp_q.push_back('0);
      end else begin
        n++;
        e_lvl = '0; e_pr = '0; e_rl = '0; e_act = '0;
        for (int i = 0; i < N; i++) begin
          s_old   = m_s1[i];
          m_s1[i] = m_s0[i];
          m_s0[i] = btn_raw[i];
          rise = 0; fall = 0; act = 0;
          run[i] = (s_old != m_lvl[i]) ? run[i] + 1 : 0;
          if (run[i] == DEB) begin
            m_lvl[i] = s_old;
            run[i]   = 0;
            rise     = s_old;
            fall     = !s_old;
          end
          if (rise) begin
            act      = 1;
            alive[i] = rep_en[i];
            tp[i]    = n;
          end else if (alive[i]) begin
            if (fall || !rep_en[i]) begin
              alive[i] = 0;
            end else begin
              d   = n - tp[i];
              act = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
            end
          end
          e_lvl[i] = m_lvl[i]; e_pr[i] = rise; e_rl[i] = fall; e_act[i] = act;
        end
        exp_q.push_back({e_lvl, e_pr, e_rl, e_act});
      end
    end
  end

  initial begin : monitor
    logic [4*N-1:0] exp_v;
    for (int i = 0; i < N; i++) begin
      act_cnt[i] = 0; press_cnt[i] = 0; rel_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at t=%0t", $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (!rst_n) exp_v = '0;
        check("outputs{lvl,press,rel,act}", 32'({btn_level, btn_press, btn_release, btn_act}),
              32'(exp_v));
        if (rst_n) begin
          for (int i = 0; i < N; i++) begin
            act_cnt[i]   += int'(btn_act[i]);
            press_cnt[i] += int'(btn_press[i]);
            rel_cnt[i]   += int'(btn_release[i]);
          end
        end
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Cycles (bounded) until every bit in mask pulses on the chosen output; returns 99 on timeout.
  task automatic latency(input logic [N-1:0] mask, input bit rel, output int c);
    c = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (((rel ? btn_release : btn_press) & mask) == mask) begin
        c = k;
        break;
      end
    end
  endtask

  initial begin : driver
    int lat, a0, p0, r0;

    // 1: reset with both buttons held, then fresh presses 6 cycles after release
    rst_n = 1'b0; btn_raw = 2'b11; rep_en = '0;
    cycles(3);
    check("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_act}), 32'd0);
    rst_n = 1'b1;
    latency(2'b11, 1'b0, lat);
    check("reset_release_press_latency", lat, 6);
    check("reset_release_act", 32'(btn_act), 32'h3);
    btn_raw = '0;
    cycles(15);

    // 2: bounce on ch0, then a clean hold
    a0 = act_cnt[0]; p0 = press_cnt[0];
    for (int k = 0; k < 10; k++) begin
      btn_raw[0] = (k % 2 == 0);
      cycles(2);
    end
    check("bounce_no_press", press_cnt[0] - p0, 0);
    btn_raw[0] = 1'b1;
    latency(2'b01, 1'b0, lat);
    check("bounce_press_latency", lat, 6);
    cycles(3);
    check("bounce_press_count", press_cnt[0] - p0, 1);
    check("bounce_act_count", act_cnt[0] - a0, 1);
    btn_raw[0] = 1'b0;
    cycles(15);

    // 3: auto-repeat, held exactly 40 cycles of level so the t+40 strobe loses to release
    a0 = act_cnt[0]; p0 = press_cnt[0]; r0 = rel_cnt[0];
    rep_en[0] = 1'b1;
    btn_raw[0] = 1'b1;
    cycles(40);
    btn_raw[0] = 1'b0;
    cycles(15);
    check("repeat_act_count", act_cnt[0] - a0, 7);
    check("repeat_press_count", press_cnt[0] - p0, 1);
    check("repeat_release_count", rel_cnt[0] - r0, 1);

    // 4: repeat disabled
    a0 = act_cnt[0]; r0 = rel_cnt[0];
    rep_en[0] = 1'b0;
    btn_raw[0] = 1'b1;
    cycles(30);
    btn_raw[0] = 1'b0;
    latency(2'b01, 1'b1, lat);
    check("norepeat_release_latency", lat, 6);
    cycles(5);
    check("norepeat_act_count", act_cnt[0] - a0, 1);
    check("norepeat_release_count", rel_cnt[0] - r0, 1);

    // 5: release during DELAY, then re-press
    a0 = act_cnt[0];
    rep_en[0] = 1'b1;
    btn_raw[0] = 1'b1;
    cycles(7);
    btn_raw[0] = 1'b0;
    cycles(20);
    check("delay_release_act_count", act_cnt[0] - a0, 1);
    btn_raw[0] = 1'b1;
    cycles(7);
    btn_raw[0] = 1'b0;
    cycles(20);
    check("repress_act_count", act_cnt[0] - a0, 2);

    // 6: ch0 repeating while ch1 presses, then reset mid-repeat with both held
    rep_en = 2'b11;
    btn_raw[0] = 1'b1;
    cycles(20);
    btn_raw[1] = 1'b1;
    cycles(23);
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", 32'({btn_level, btn_press, btn_release, btn_act}), 32'd0);
    cycles(3);
    rst_n = 1'b1;
    latency(2'b11, 1'b0, lat);
    check("midop_reset_fresh_press", lat, 6);
    btn_raw = '0;
    cycles(20);

    // randomized traffic: glitches, accepted levels, rep_en changes, occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
        if ($urandom_range(0, 39) == 0) rep_en[i] = ~rep_en[i];
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
      end
      cycles(1);
    end
    btn_raw = '0;
    cycles(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
